// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch/jump flushes, multi-cycle MEM freeze.
// Optional stall/flush statistics counters are compiled in with `define HAZARD_STALL_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int MEM_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             mem_req_i,
    output logic             pc_write_o,
    output logic             ifid_hold_o,
    output logic             flush1_o,
    output logic             flush2_o,
    output logic             idex_bubble_o,
`ifdef HAZARD_STALL_CNT_EN
    output logic [CNT_W-1:0] lu_stall_cnt_o,
    output logic [CNT_W-1:0] mem_stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
`endif
    output logic             busy_o
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    // The RUN cycle that sees mem_req is the first frozen cycle, so MEM_WAIT
    // lasts MEM_LAT-2 cycles; the counter holds the wait cycles left after the current one.
    localparam bit MEM_STALL  = (MEM_LAT > 1);
    localparam bit MEM_ENTER  = (MEM_LAT > 2);
    localparam int WAIT_W     = MEM_ENTER ? $clog2(MEM_LAT - 1) : 1;
    localparam int WAIT_INIT  = MEM_ENTER ? MEM_LAT - 3 : 0;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              mem_start;

    always_comb begin
        load_use  = ex_memread_i && (ex_rt_i != 5'd0) &&
                    ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
        mem_start = MEM_STALL && (state == RUN) && mem_req_i;
    end

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_hold_o   = 1'b0;
        flush1_o      = 1'b0;
        flush2_o      = 1'b0;
        idex_bubble_o = 1'b0;
        busy_o        = 1'b0;
        if (!rst_n) begin
            pc_write_o = 1'b1;
        end else if (state == MEM_WAIT) begin
            pc_write_o  = 1'b0;
            ifid_hold_o = 1'b1;
            busy_o      = 1'b1;
        end else if (mem_start) begin
            pc_write_o  = 1'b0;
            ifid_hold_o = 1'b1;
        end else if (load_use) begin
            pc_write_o    = 1'b0;
            ifid_hold_o   = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (jump_i) begin
            flush2_o = 1'b1;
        end else if (branch_taken_i) begin
            flush1_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_start && MEM_ENTER) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(WAIT_INIT);
                    end
                end
                MEM_WAIT: begin
                    if (wait_cnt == '0) state <= RUN;
                    else                wait_cnt <= wait_cnt - 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] lu_cnt, mem_cnt, fl_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
        return (ev && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lu_cnt  <= '0;
            mem_cnt <= '0;
            fl_cnt  <= '0;
        end else begin
            lu_cnt  <= sat_inc(lu_cnt, idex_bubble_o);
            mem_cnt <= sat_inc(mem_cnt, mem_start || (state == MEM_WAIT));
            fl_cnt  <= sat_inc(fl_cnt, flush1_o || flush2_o);
        end
    end

    assign lu_stall_cnt_o  = lu_cnt;
    assign mem_stall_cnt_o = mem_cnt;
    assign flush_cnt_o     = fl_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: three instances (MEM_LAT=1,3,5) share one stimulus stream.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_memread, branch_taken, jump, mem_req;

    // index 0: MEM_LAT=1, 1: MEM_LAT=3, 2: MEM_LAT=5
    logic [2:0] pc_w, hold, f1, f2, bub, busy;
`ifdef HAZARD_STALL_CNT_EN
    logic [2:0][1:0] lu_cnt, mem_cnt, fl_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_LAT(1), .CNT_W(2)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .branch_taken_i(branch_taken),
        .jump_i(jump), .mem_req_i(mem_req), .pc_write_o(pc_w[0]), .ifid_hold_o(hold[0]),
        .flush1_o(f1[0]), .flush2_o(f2[0]), .idex_bubble_o(bub[0]),
`ifdef HAZARD_STALL_CNT_EN
        .lu_stall_cnt_o(lu_cnt[0]), .mem_stall_cnt_o(mem_cnt[0]), .flush_cnt_o(fl_cnt[0]),
`endif
        .busy_o(busy[0]));

    pipeline_hazard_ctrl #(.MEM_LAT(3), .CNT_W(2)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .branch_taken_i(branch_taken),
        .jump_i(jump), .mem_req_i(mem_req), .pc_write_o(pc_w[1]), .ifid_hold_o(hold[1]),
        .flush1_o(f1[1]), .flush2_o(f2[1]), .idex_bubble_o(bub[1]),
`ifdef HAZARD_STALL_CNT_EN
        .lu_stall_cnt_o(lu_cnt[1]), .mem_stall_cnt_o(mem_cnt[1]), .flush_cnt_o(fl_cnt[1]),
`endif
        .busy_o(busy[1]));

    pipeline_hazard_ctrl #(.MEM_LAT(5), .CNT_W(2)) u_lat5 (
        .clk(clk), .rst_n(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .branch_taken_i(branch_taken),
        .jump_i(jump), .mem_req_i(mem_req), .pc_write_o(pc_w[2]), .ifid_hold_o(hold[2]),
        .flush1_o(f1[2]), .flush2_o(f2[2]), .idex_bubble_o(bub[2]),
`ifdef HAZARD_STALL_CNT_EN
        .lu_stall_cnt_o(lu_cnt[2]), .mem_stall_cnt_o(mem_cnt[2]), .flush_cnt_o(fl_cnt[2]),
`endif
        .busy_o(busy[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs for the next cycle are driven 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        ex_memread = 1'b0; branch_taken = 1'b0; jump = 1'b0; mem_req = 1'b0;
    endtask

    // Load-use on rs (reg 8), one cycle, then an idle cycle.
    task automatic lu_pulse();
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        tick();
        idle_in();
        tick();
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        #1;
        // {pc, hold, f1, f2, bub, busy} for the MEM_LAT=3 instance
        chk("reset_forced", {pc_w[1], hold[1], f1[1], f2[1], bub[1], busy[1]}, 6'b100000);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("idle_run", {pc_w[1], hold[1], f1[1], f2[1], bub[1], busy[1]}, 6'b100000);

        // load-use via rs
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #1;
        chk("lu_rs_stall", {pc_w[1], hold[1], f1[1], f2[1], bub[1], busy[1]}, 6'b010010);
        tick();
        ex_memread = 1'b0; #1;
        chk("lu_released", {pc_w[1], hold[1], bub[1]}, 3'b100);

        // zero register is never a hazard
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; #1;
        chk("zero_reg", {pc_w[1], hold[1], bub[1]}, 3'b100);
        tick();

        // load-use via rt, and a non-matching load
        ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd3; #1;
        chk("lu_rt_stall", {pc_w[1], hold[1], bub[1]}, 3'b011);
        id_rt = 5'd6; #1;
        chk("no_match", {pc_w[1], hold[1], bub[1]}, 3'b100);
        tick();
        idle_in();

        // jump beats branch
        jump = 1'b1; branch_taken = 1'b1; #1;
        chk("jump_and_branch", {pc_w[1], hold[1], f1[1], f2[1], bub[1]}, 5'b10010);
        jump = 1'b0; #1;
        chk("branch_only", {pc_w[1], hold[1], f1[1], f2[1], bub[1]}, 5'b10100);
        // load-use outranks branch
        ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; #1;
        chk("lu_over_branch", {pc_w[1], f1[1], bub[1]}, 3'b001);
        tick();
        idle_in();
        tick();

        // memory access together with a load-use hazard
        mem_req = 1'b1; ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #1;
        chk("mem_c0_lat3", {pc_w[1], hold[1], bub[1], busy[1]}, 4'b0100);
        chk("mem_c0_lat5", {pc_w[2], busy[2]}, 2'b00);
        chk("mem_c0_lat1", {pc_w[0], bub[0], busy[0]}, 3'b010);
        tick();
        // mem_req again here must be ignored by the waiting instances
        #1;
        chk("mem_c1_lat3", {pc_w[1], hold[1], f1[1], f2[1], bub[1], busy[1]}, 6'b010001);
        chk("mem_c1_lat5", {pc_w[2], bub[2], busy[2]}, 3'b001);
        tick();
        idle_in(); #1;
        chk("mem_c2_lat3", {pc_w[1], hold[1], busy[1]}, 3'b100);
        chk("mem_c2_lat5", {pc_w[2], busy[2]}, 2'b01);
        tick();
        chk("mem_c3_lat5", {pc_w[2], busy[2]}, 2'b01);
        tick();
        chk("mem_c4_lat5", {pc_w[2], hold[2], busy[2]}, 3'b100);
        tick();

        // reset during the second MEM_WAIT cycle of MEM_LAT=5
        mem_req = 1'b1; #1;
        tick();
        mem_req = 1'b0; #1;
        chk("rst_w1_busy", {pc_w[2], busy[2]}, 2'b01);
        tick();
        rst_n = 1'b0; #1;
        chk("rst_w2_forced", {pc_w[2], hold[2], busy[2]}, 3'b100);
        tick();
        rst_n = 1'b1; #1;
        chk("rst_after", {pc_w[2], busy[2]}, 2'b10);
        tick();
        chk("rst_after2", {pc_w[2], busy[2]}, 2'b10);

`ifdef HAZARD_STALL_CNT_EN
        chk("cnt_clear", {lu_cnt[1], mem_cnt[1], fl_cnt[1]}, 6'd0);
        lu_pulse(); lu_pulse();
        chk("lu_cnt_2", lu_cnt[1], 2);
        lu_pulse(); lu_pulse(); lu_pulse();
        chk("lu_cnt_sat", lu_cnt[1], 3);
        jump = 1'b1; tick();
        idle_in(); tick();
        chk("flush_cnt", fl_cnt[1], 1);
        mem_req = 1'b1; tick();
        idle_in(); tick(); tick();
        chk("mem_cnt_lat3", mem_cnt[1], 2);
        chk("mem_cnt_lat5", mem_cnt[2], 3);
        chk("mem_cnt_lat1", mem_cnt[0], 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
